uart_tx_arbiter: RTL

- Shares the single CoreUART transmitter in Minimal_SoC between N byte-stream requesters, e.g. telemetry, debug and GPIO-event sources.
- Arbitrates round-robin on packet boundaries.
- Sequences each byte into the UART through the DATA_IN/WEN/TXRDY handshake.
- Sits between the requester logic and the UART instance, in the same clock domain as SYSCLK.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester and CoreUART handshake bundle for uart_tx_arbiter.
// The arbiter takes the slave modport; requesters and UART sit on the master side.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]   REQ_VALID;
  logic [8*N_REQ-1:0] REQ_DATA;
  logic [N_REQ-1:0]   REQ_LAST;
  logic [N_REQ-1:0]   REQ_READY;
  logic [N_REQ-1:0]   GRANT;
  logic [7:0]         UART_DATA_IN;
  logic               UART_WEN_N;
  logic               UART_TXRDY;
  logic               BUSY;

  modport master (
    output REQ_VALID, REQ_DATA, REQ_LAST, UART_TXRDY,
    input  REQ_READY, GRANT, UART_DATA_IN, UART_WEN_N, BUSY
  );

  modport slave (
    input  REQ_VALID, REQ_DATA, REQ_LAST, UART_TXRDY,
    output REQ_READY, GRANT, UART_DATA_IN, UART_WEN_N, BUSY
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one CoreUART transmitter between N_REQ byte streams.
// Define UART_TX_ARB_SRC_TAG_EN to prefix every packet with a source-ID byte {4'hA, grant index}.
module uart_tx_arbiter #(
  parameter int N_REQ         = 3,
  parameter int TXRDY_HOLDOFF = 2
) (
  input logic             SYSCLK,
  input logic             SYSRESET,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TXRDY_HOLDOFF + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_HOLD,
    ST_WAIT_RDY
`ifdef UART_TX_ARB_SRC_TAG_EN
    , ST_TAG
`endif
  } state_t;

  state_t             state_reg, state_next;
  logic [N_REQ-1:0]   grant_reg, grant_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [7:0]         data_reg, data_next;
  logic               last_reg, last_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               wen_n_reg;

  logic [7:0]         req_byte [N_REQ];
  logic [N_REQ-1:0]   ready_vec;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   pick_onehot;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % N_REQ);
  endfunction

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign req_byte[gi]  = bus.REQ_DATA[8*gi +: 8];
    assign ready_vec[gi] = (state_reg == ST_LOAD) && grant_reg[gi];
  end

  // First valid requester at or after the pointer, wrapping upward.
  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = ptr_reg;
    pick_onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_found && bus.REQ_VALID[wrap_idx(int'(ptr_reg) + k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_idx(int'(ptr_reg) + k);
      end
    end
    pick_onehot[pick_idx] = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    idx_next   = idx_reg;
    ptr_next   = ptr_reg;
    data_next  = data_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick_found && bus.UART_TXRDY) begin
          grant_next = pick_onehot;
          idx_next   = pick_idx;
`ifdef UART_TX_ARB_SRC_TAG_EN
          state_next = ST_TAG;
`else
          state_next = ST_LOAD;
`endif
        end
      end
`ifdef UART_TX_ARB_SRC_TAG_EN
      ST_TAG: begin
        data_next  = {4'hA, 4'(idx_reg)};
        last_next  = 1'b0;
        state_next = ST_WRITE;
      end
`endif
      // No timeout: a stalled owner keeps the UART until it resumes.
      ST_LOAD: begin
        if (bus.REQ_VALID[idx_reg]) begin
          data_next  = req_byte[idx_reg];
          last_next  = bus.REQ_LAST[idx_reg];
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cnt_next   = '0;
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_reg == CNT_W'(TXRDY_HOLDOFF - 1)) begin
          state_next = ST_WAIT_RDY;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_WAIT_RDY: begin
        if (bus.UART_TXRDY) begin
          if (last_reg) begin
            state_next = ST_IDLE;
            grant_next = '0;
            ptr_next   = (idx_reg == IDX_W'(N_REQ - 1)) ? '0 : idx_reg + 1'b1;
          end else begin
            state_next = ST_LOAD;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The strobe is a flop so it cannot glitch while state bits change or reset asserts.
  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      state_reg <= ST_IDLE;
      grant_reg <= '0;
      idx_reg   <= '0;
      ptr_reg   <= '0;
      data_reg  <= 8'h00;
      last_reg  <= 1'b0;
      cnt_reg   <= '0;
      wen_n_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      idx_reg   <= idx_next;
      ptr_reg   <= ptr_next;
      data_reg  <= data_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
      wen_n_reg <= (state_next != ST_WRITE);
    end
  end

  assign bus.REQ_READY    = ready_vec;
  assign bus.GRANT        = grant_reg;
  assign bus.UART_DATA_IN = data_reg;
  assign bus.UART_WEN_N   = wen_n_reg;
  assign bus.BUSY         = (state_reg != ST_IDLE);

endmodule
